div_result_disp: RTL and testbench
==================================

Name: div_result_disp

Overview:
- Downstream consumer of the 4-bit combinational divider (quotient `s`, remainder `r`).
- On a load strobe it captures quotient, remainder and a divide-by-zero flag, then converts each to BCD with an iterative shift-add-3 (double-dabble).
- It drives a 4-digit multiplexed active-low 7-segment display: quotient on the left two digits, remainder on the right two.
- Includes a one-deep pending buffer, so a load arriving mid-conversion is never lost.

Parameters:
- SCAN_W, 16, width of the scan prescaler; the digit advances each time the prescaler wraps (period 2^SCAN_W clocks).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- load  in  1  single-cycle strobe: capture quo/rem/dz this cycle.
- quo  in  4  quotient from the divider.
- rem  in  4  remainder from the divider.
- dz  in  1  divisor was zero; show error pattern instead of digits.
- busy  out  1  conversion in progress.
- valid  out  1  display holds a converted result (sticky until reset).
- seg  out  7  {g,f,e,d,c,b,a}, active-low.
- an  out  4  digit enables, active-low; an[3]=quo tens, an[2]=quo ones, an[1]=rem tens, an[0]=rem ones.

Behaviour:
- Reset (async, rst_n=0): FSM=IDLE, busy=0, valid=0, pending=0, prescaler=0, scan index=0, seg=7'h7F, an=4'hF. Reset mid-conversion discards all operands.
- FSM states are IDLE, CONV, COMMIT.
- IDLE:
  - load=1 captures quo/rem/dz into work registers.
  - Next state is CONV with iteration count 0.
- CONV (4 cycles, busy=1):
  - Each of the two 9-bit shift registers {tens[0], ones[3:0], bin[3:0]} works per cycle as follows: if ones>=5 then ones+=3 (4-bit, no overflow possible); then shift the whole register left 1.
  - After the 4th cycle, go to COMMIT.
- COMMIT (1 cycle, busy=1):
  - Copy BCD digits and dz to display registers; set valid=1.
  - If pending=1, reload from the pending buffer, clear pending, go to CONV. Otherwise go to IDLE.
- Latency: load at cycle N, then busy=1 in cycles N+1..N+5 and display registers updated at the end of N+5. Back-to-back result every 5 cycles.
- load while busy:
  - Store into the pending buffer; latest value wins and overwrites an earlier pending entry.
  - load in the COMMIT cycle also goes to pending and is taken immediately by that COMMIT.
- Scan:
  - Prescaler free-runs from reset.
  - On wrap, scan index increments 0→1→2→3→0 (2-bit wrap).
  - an = ~(1<<index) when valid=1. When valid=0, an=4'hF and seg=7'h7F.
- Segment codes:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, '-'=0111111, blank=1111111.
  - dz=1 in the display register: all four digits show '-'.
- Display registers change only in COMMIT; scanning never stalls during conversion, so the old result stays visible until COMMIT.

Optional Feature:
- DIV_DISP_LZB_EN defined: leading-zero blanking. A tens digit equal to 0 shows blank (an still cycles). Not applied to '-' patterns.
- Undefined: tens digits always show their numeral, including 0.

Decomposition:
- Package div_disp_pkg holds:
  - FSM state enum (IDLE, CONV, COMMIT).
  - 7-bit segment constants SEG_0..SEG_9, SEG_DASH, SEG_BLANK.
  - CONV_ITERS=4.
- One sub-module: bin4_to_bcd_step. It is combinational: given a 9-bit dabble register, it returns the next register. Instantiated twice (quotient, remainder).

Test Plan:
- Reset: assert rst_n=0 mid-run → seg=7'h7F, an=4'hF, busy=0, valid=0 immediately (async).
- SCAN_W=2, load quo=7 rem=1 dz=0 → busy high 5 cycles, valid=1. Scan shows an[3]=1000000 (or blank with LZB), an[2]=1111000, an[1]=1000000/blank, an[0]=1111001.
- load quo=15 rem=0 → an[3]=1111001, an[2]=0010010, an[1] 0/blank, an[0]=1000000. Repeat for all 16 quo values vs a golden BCD table.
- load dz=1 (quo=15 rem=15) → all four digits 0111111 regardless of DIV_DISP_LZB_EN.
- load quo=5 rem=3, then load quo=2 rem=1 two cycles later and quo=9 rem=0 one cycle after that:
  - first result commits at +5; pending restart follows.
  - final display shows 9/0; 2/1 never committed; busy continuous for 10 cycles.
- Load asserted in the COMMIT cycle → second conversion starts with no IDLE cycle; no load is dropped.

Source files
------------

// File: rtl/div_disp_pkg.sv
// div_disp_pkg: FSM states, 7-segment codes (active-low {g,f,e,d,c,b,a}) and
// dabble iteration count shared by div_result_disp.
package div_disp_pkg;
  typedef enum logic [1:0] {IDLE, CONV, COMMIT} state_t;
  localparam int CONV_ITERS = 4;
  localparam logic [6:0] SEG_0     = 7'b1000000;
  localparam logic [6:0] SEG_1     = 7'b1111001;
  localparam logic [6:0] SEG_2     = 7'b0100100;
  localparam logic [6:0] SEG_3     = 7'b0110000;
  localparam logic [6:0] SEG_4     = 7'b0011001;
  localparam logic [6:0] SEG_5     = 7'b0010010;
  localparam logic [6:0] SEG_6     = 7'b0000010;
  localparam logic [6:0] SEG_7     = 7'b1111000;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0010000;
  localparam logic [6:0] SEG_DASH  = 7'b0111111;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  function automatic logic [6:0] seg_of(input logic [3:0] d);
    return d == 4'd0 ? SEG_0 : d == 4'd1 ? SEG_1 : d == 4'd2 ? SEG_2 :
           d == 4'd3 ? SEG_3 : d == 4'd4 ? SEG_4 : d == 4'd5 ? SEG_5 :
           d == 4'd6 ? SEG_6 : d == 4'd7 ? SEG_7 : d == 4'd8 ? SEG_8 :
           d == 4'd9 ? SEG_9 : SEG_BLANK;
  endfunction
endpackage

// File: rtl/div_result_disp_step.sv
// bin4_to_bcd_step: one shift-add-3 iteration on a {tens, ones[3:0], bin[3:0]} register.
module bin4_to_bcd_step (
  input  logic [8:0] i_dab,
  output logic [8:0] o_dab
);
  logic [3:0] w_ones;
  assign w_ones = i_dab[7:4] >= 4'd5 ? i_dab[7:4] + 4'd3 : i_dab[7:4];
  assign o_dab  = {w_ones, i_dab[3:0], 1'b0};
endmodule

// File: rtl/div_result_disp.sv
// div_result_disp: captures divider quotient/remainder, converts to BCD and scans a 4-digit
// active-low 7-segment display. Define DIV_DISP_LZB_EN for tens-digit leading-zero blanking.
module div_result_disp
  import div_disp_pkg::*;
#(
  parameter int SCAN_W = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] quo,
  input  logic [3:0] rem,
  input  logic       dz,
  output logic       busy,
  output logic       valid,
  output logic [6:0] seg,
  output logic [3:0] an
);
  state_t r_state, w_next;
  logic [1:0] r_iter, r_idx;
  logic [8:0] r_qd, r_rd, w_qn, w_rn;
  logic r_dz, r_pend, r_pdz, r_dq_t, r_dr_t, r_ddz, r_valid;
  logic [3:0] r_pq, r_pr, r_dq_o, r_dr_o, w_src_q, w_src_r, w_digit;
  logic [SCAN_W-1:0] r_pre;
  logic w_last, w_reload, w_start, w_src_dz, w_blank;

  bin4_to_bcd_step u_q (.i_dab(r_qd), .o_dab(w_qn));
  bin4_to_bcd_step u_r (.i_dab(r_rd), .o_dab(w_rn));

  assign w_last   = r_iter == 2'(CONV_ITERS - 1);
  assign w_reload = r_pend | load;
  assign w_start  = (r_state == IDLE && load) || (r_state == COMMIT && w_reload);
  // A load in the COMMIT cycle is newer than anything pending, so it wins.
  assign w_src_q  = load ? quo : r_pq;
  assign w_src_r  = load ? rem : r_pr;
  assign w_src_dz = load ? dz : r_pdz;

  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (load ? CONV : IDLE) :
             r_state == CONV ? (w_last ? COMMIT : CONV) :
             (w_reload ? CONV : IDLE);
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_iter  <= '0;
      r_qd    <= '0;
      r_rd    <= '0;
      r_dz    <= 1'b0;
      r_pend  <= 1'b0;
      r_pq    <= '0;
      r_pr    <= '0;
      r_pdz   <= 1'b0;
      r_dq_t  <= 1'b0;
      r_dq_o  <= '0;
      r_dr_t  <= 1'b0;
      r_dr_o  <= '0;
      r_ddz   <= 1'b0;
      r_valid <= 1'b0;
    end else begin
      if (w_start) begin
        r_qd   <= {5'b0, w_src_q};
        r_rd   <= {5'b0, w_src_r};
        r_dz   <= w_src_dz;
        r_iter <= '0;
      end else if (r_state == CONV) begin
        r_qd   <= w_qn;
        r_rd   <= w_rn;
        r_iter <= r_iter + 2'd1;
      end
      if (r_state == COMMIT) begin
        r_pend  <= 1'b0;
        r_dq_t  <= r_qd[8];
        r_dq_o  <= r_qd[7:4];
        r_dr_t  <= r_rd[8];
        r_dr_o  <= r_rd[7:4];
        r_ddz   <= r_dz;
        r_valid <= 1'b1;
      end else if (r_state == CONV && load) begin
        r_pend <= 1'b1;
        r_pq   <= quo;
        r_pr   <= rem;
        r_pdz  <= dz;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pre <= '0;
      r_idx <= '0;
    end else begin
      r_pre <= r_pre + 1'b1;
      if (&r_pre) r_idx <= r_idx + 2'd1;
    end
  end

  assign w_digit = r_idx == 2'd3 ? {3'b0, r_dq_t} : r_idx == 2'd2 ? r_dq_o :
                   r_idx == 2'd1 ? {3'b0, r_dr_t} : r_dr_o;
`ifdef DIV_DISP_LZB_EN
  assign w_blank = r_idx[0] && w_digit == 4'd0;
`else
  assign w_blank = 1'b0;
`endif
  assign busy  = r_state != IDLE;
  assign valid = r_valid;
  assign seg   = !r_valid ? SEG_BLANK : r_ddz ? SEG_DASH : w_blank ? SEG_BLANK : seg_of(w_digit);
  assign an    = r_valid ? ~(4'b1 << r_idx) : 4'hF;
endmodule

// File: tb/tb_div_result_disp.sv
// tb_div_result_disp: random and directed loads checked every cycle against a timeline model
// of the display, plus literal segment patterns for known results.
module tb_div_result_disp;
  logic clk, rst_n, load, dz, busy, valid;
  logic [3:0] quo, rem, an;
  logic [6:0] seg;
  int n_chk, n_fail;
  int m_cnt, t, run, last_run, m_cq, m_cr, m_pq, m_pr, m_dq, m_dr;
  bit m_valid, m_pv, m_cdz, m_pdz, m_ddz;
  localparam logic [6:0] DASH  = 7'b0111111;
  localparam logic [6:0] BLANK = 7'b1111111;
`ifdef DIV_DISP_LZB_EN
  localparam logic [6:0] TZ = BLANK;
`else
  localparam logic [6:0] TZ = 7'b1000000;
`endif
  logic [6:0] segt [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                            7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};

  div_result_disp #(.SCAN_W(2)) dut (
    .clk(clk), .rst_n(rst_n), .load(load), .quo(quo), .rem(rem), .dz(dz),
    .busy(busy), .valid(valid), .seg(seg), .an(an)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic logic [6:0] mseg(input int i);
    int v;
    v = i == 3 ? m_dq / 10 : i == 2 ? m_dq % 10 : i == 1 ? m_dr / 10 : m_dr % 10;
    if (m_ddz) return DASH;
`ifdef DIV_DISP_LZB_EN
    if (i % 2 == 1 && v == 0) return BLANK;
`endif
    return segt[v];
  endfunction

  // Model: m_cnt = busy cycles left including the current one; each result takes 5 busy cycles.
  initial begin
    int idx;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_cnt = 0; m_pv = 0; m_valid = 0; t = 0; run = 0;
      end else begin
        idx = (t / 4) % 4;
        chk("busy", busy, int'(m_cnt > 0));
        chk("valid", valid, m_valid);
        chk("an", an, m_valid ? (~(1 << idx)) & 15 : 15);
        chk("seg", seg, m_valid ? mseg(idx) : 7'h7F);
        if (busy) run++;
        else if (run > 0) begin last_run = run; run = 0; end
        t++;
        if (m_cnt == 0) begin
          if (load) begin m_cq = quo; m_cr = rem; m_cdz = dz; m_cnt = 5; end
        end else if (m_cnt == 1) begin
          m_dq = m_cq; m_dr = m_cr; m_ddz = m_cdz; m_valid = 1;
          if (load) begin m_cq = quo; m_cr = rem; m_cdz = dz; m_cnt = 5; end
          else if (m_pv) begin m_cq = m_pq; m_cr = m_pr; m_cdz = m_pdz; m_cnt = 5; end
          else m_cnt = 0;
          m_pv = 0;
        end else begin
          if (load) begin m_pq = quo; m_pr = rem; m_pdz = dz; m_pv = 1; end
          m_cnt--;
        end
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic ld(input logic [3:0] q, input logic [3:0] r, input logic d);
    load = 1; quo = q; rem = r; dz = d;
    step(1);
    load = 0;
  endtask

  task automatic dig(input string nm, input logic [3:0] a, input logic [6:0] e);
    int k = 0;
    while (an !== a && k < 40) begin step(1); k++; end
    if (k == 40) begin
      n_chk++; n_fail++;
      $display("FAIL %s: digit enable %b never seen, got %b", nm, a, an);
    end else chk(nm, seg, e);
  endtask

  task automatic rnd(input int n);
    repeat (n)
      if ($urandom_range(0, 3) == 0)
        ld(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), $urandom_range(0, 9) == 0);
      else step(1);
  endtask

  initial begin
    rst_n = 0; load = 0; quo = 0; rem = 0; dz = 0; last_run = 0;
    step(3);
    rst_n = 1;
    step(2);
    chk("reset_valid", valid, 0);
    chk("reset_an", an, 4'hF);
    chk("reset_seg", seg, 7'h7F);
    last_run = 0;
    ld(7, 1, 0);
    step(8);
    chk("run_single", last_run, 5);
    dig("q7_tens", 4'b0111, TZ);
    dig("q7_ones", 4'b1011, 7'b1111000);
    dig("r1_tens", 4'b1101, TZ);
    dig("r1_ones", 4'b1110, 7'b1111001);
    ld(15, 0, 0);
    step(8);
    dig("q15_tens", 4'b0111, 7'b1111001);
    dig("q15_ones", 4'b1011, 7'b0010010);
    dig("r0_tens", 4'b1101, TZ);
    dig("r0_ones", 4'b1110, 7'b1000000);
    for (int q = 0; q < 16; q++) begin
      ld(4'(q), 4'(15 - q), 0);
      step(20);
    end
    ld(15, 15, 1);
    step(8);
    dig("dz_3", 4'b0111, DASH);
    dig("dz_2", 4'b1011, DASH);
    dig("dz_1", 4'b1101, DASH);
    dig("dz_0", 4'b1110, DASH);
    last_run = 0;
    ld(5, 3, 0);
    step(1);
    ld(2, 1, 0);
    ld(9, 0, 0);
    step(10);
    chk("run_pending", last_run, 10);
    dig("pend_q_ones", 4'b1011, 7'b0010000);
    dig("pend_r_ones", 4'b1110, 7'b1000000);
    last_run = 0;
    ld(3, 4, 0);
    step(4);
    ld(6, 2, 0);
    step(10);
    chk("run_commit_load", last_run, 10);
    dig("cl_q_ones", 4'b1011, 7'b0000010);
    dig("cl_r_ones", 4'b1110, 7'b0100100);
    rnd(300);
    ld(8, 8, 0);
    step(2);
    #2 rst_n = 0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_valid", valid, 0);
    chk("async_an", an, 4'hF);
    chk("async_seg", seg, 7'h7F);
    @(posedge clk);
    #1 rst_n = 1;
    step(20);
    chk("post_reset_valid", valid, 0);
    rnd(150);
    step(20);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
